// File: rtl/lake_config_loader.sv
// lake_config_loader
//
// Collects a configuration image one bus word at a time into a shadow
// register and commits the whole shadow to config_memory on flush. The
// committed image feeds the downstream lakespec config_memory input, so
// the shadow can be rewritten freely without disturbing a running image.
//
// Optional feature macro: LAKE_CONFIG_READBACK_EN
//   defined   : config_read returns the shadow word one cycle later and
//               out-of-range reads set config_err.
//   undefined : config_rd_data / config_rd_valid are tied to 0 and
//               config_read is ignored.
//
// Ports
//   clk                 single clock, rising edge
//   rst_n               asynchronous active-low reset
//   flush               commit request (only acts in LOADING)
//   config_config_addr  word index for read/write
//   config_config_data  write data
//   config_write        write strobe, one word per cycle
//   config_read         read strobe
//   config_rd_data      read-back data, held while config_rd_valid is low
//   config_rd_valid     one-cycle qualifier for config_rd_data
//   config_memory       committed image
//   config_loaded       high while the FSM is COMMITTED
//   config_err          sticky out-of-range access flag (cleared by reset)
//   dbg_state           FSM state: 0 IDLE, 1 LOADING, 2 COMMITTED
//
// Handshake: there is no backpressure. A strobe sampled high at a rising
// edge is always accepted at that edge; reads answer exactly one cycle
// later with a single-cycle config_rd_valid pulse.

module lake_config_loader #(
    parameter int CONFIG_MEMORY_SIZE = 512,
    parameter int WORD_WIDTH         = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [31:0]                   config_config_addr,
    input  logic [WORD_WIDTH-1:0]         config_config_data,
    input  logic                          config_write,
    input  logic                          config_read,
    output logic [WORD_WIDTH-1:0]         config_rd_data,
    output logic                          config_rd_valid,
    output logic [CONFIG_MEMORY_SIZE-1:0] config_memory,
    output logic                          config_loaded,
    output logic                          config_err,
    output logic [1:0]                    dbg_state
);

    localparam int NW        = (CONFIG_MEMORY_SIZE + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int LAST_BITS = CONFIG_MEMORY_SIZE - (NW - 1) * WORD_WIDTH;
    // Only the bits of the last word that land inside the image are stored.
    localparam logic [WORD_WIDTH-1:0] LAST_MASK =
        {WORD_WIDTH{1'b1}} >> (WORD_WIDTH - LAST_BITS);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOADING   = 2'd1,
        ST_COMMITTED = 2'd2
    } state_t;

    state_t                     state;
    logic [WORD_WIDTH-1:0]      shadow [NW];
    logic [NW*WORD_WIDTH-1:0]   shadow_flat;
    logic                       addr_in_range;
    logic                       wr_ok;
    logic                       wr_bad;
    logic                       rd_bad;

    assign addr_in_range = (config_config_addr < 32'(NW));
    assign wr_ok         = config_write && addr_in_range;
    assign wr_bad        = config_write && !addr_in_range;
    assign dbg_state     = state;

    always_comb begin
        shadow_flat = '0;
        for (int k = 0; k < NW; k++) begin
            shadow_flat[k*WORD_WIDTH +: WORD_WIDTH] = shadow[k];
        end
    end

    // Shadow register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NW; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NW; k++) begin
                if (wr_ok && (config_config_addr == 32'(k))) begin
                    shadow[k] <= (k == NW - 1) ? (config_config_data & LAST_MASK)
                                               : config_config_data;
                end
            end
        end
    end

    // Commit FSM. The commit copies the shadow as it stood before this
    // edge, so a write sampled together with flush misses config_memory and
    // leaves the FSM in LOADING.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            config_memory <= '0;
            config_loaded <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wr_ok) begin
                        state <= ST_LOADING;
                    end
                end
                ST_LOADING: begin
                    if (flush) begin
                        config_memory <= shadow_flat[CONFIG_MEMORY_SIZE-1:0];
                        if (!wr_ok) begin
                            state         <= ST_COMMITTED;
                            config_loaded <= 1'b1;
                        end
                    end
                end
                ST_COMMITTED: begin
                    if (wr_ok) begin
                        state         <= ST_LOADING;
                        config_loaded <= 1'b0;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    config_loaded <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            config_err <= 1'b0;
        end else if (wr_bad || rd_bad) begin
            config_err <= 1'b1;
        end
    end

`ifdef LAKE_CONFIG_READBACK_EN
    logic [WORD_WIDTH-1:0] rd_word;

    assign rd_bad = config_read && !addr_in_range;

    // Out-of-range addresses match no word and read back as 0.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NW; k++) begin
            if (config_config_addr == 32'(k)) begin
                rd_word = shadow[k];
            end
        end
    end

    // Reads the shadow before this edge's write, giving pre-write data on
    // a same-address read/write collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            config_rd_valid <= 1'b0;
            config_rd_data  <= '0;
        end else begin
            config_rd_valid <= config_read;
            if (config_read) begin
                config_rd_data <= rd_word;
            end
        end
    end
`else
    logic unused_read;

    assign unused_read     = config_read;
    assign rd_bad          = 1'b0;
    assign config_rd_data  = '0;
    assign config_rd_valid = 1'b0;
`endif

endmodule
